// File: rtl/lsu_arb_pkg.sv
// Shared definitions for the LSU port arbiter: FSM encoding and counter widths.
package lsu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ISSUE     = 2'b01,
    WAIT_RESP = 2'b10,
    DRAIN     = 2'b11
  } state_t;

  localparam int WDOG_W  = 8;
  // Wide enough for DRAIN_CYC up to 16.
  localparam int DRAIN_W = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority pick: the search starts one past last_ptr and wraps.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    int   cand;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(last_ptr) + off) % NUM_REQ;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IDX_W'(cand);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/lsu_port_arbiter.sv
// Round-robin owner of the shared translation/dCache request port; one transaction in flight,
// with requester kill and watchdog abort. Every output comes straight from a flop.
module lsu_port_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 40,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 255,
  parameter int DRAIN_CYC   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ-1:0]        req_is_store_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  input  logic [NUM_REQ-1:0]        req_kill_i,
  output logic [NUM_REQ-1:0]        req_gnt_o,
  output logic [NUM_REQ-1:0]        resp_valid_o,
  output logic                      resp_err_o,
  output logic [DATA_W-1:0]         resp_rdata_o,
  output logic                      is_load_o,
  output logic                      is_store_o,
  output logic                      kill_mem_op_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [DATA_W-1:0]         mem_wdata_o,
  input  logic                      ld_resp_valid_i,
  input  logic                      st_resp_gnt_i,
  input  logic [DATA_W-1:0]         ld_rdata_i,
  output logic                      busy_o,
  output logic [1:0]                dbg_state_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Handshake: a requester holds req_valid_i (and its type/addr/data) until the
  // single-cycle req_gnt_o pulse; the matching resp_valid_o pulse ends the transaction.
  state_t              state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d, last_q, last_d;
  logic                store_q, store_d, kill_pend_q, kill_pend_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d, rv_q, rv_d;
  logic                err_q, err_d, ld_q, ld_d, st_q, st_d, kmo_q, kmo_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d, wdata_q, wdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_any;
  logic [NUM_REQ-1:0]  owner_oh;
  logic [WDOG_W-1:0]   wdog_inc;
  logic                done, killed, tmo;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req      (req_valid_i),
    .last_ptr (last_q),
    .gnt      (arb_gnt),
    .idx      (arb_idx),
    .any      (arb_any)
  );

  assign owner_oh = NUM_REQ'(1) << owner_q;
  assign wdog_inc = wdog_q + WDOG_W'(1);
  assign done     = store_q ? st_resp_gnt_i : ld_resp_valid_i;
  assign killed   = kill_pend_q | req_kill_i[owner_q];
  assign tmo      = (wdog_inc == WDOG_W'(TIMEOUT_CYC));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    store_d     = store_q;
    kill_pend_d = kill_pend_q;
    wdog_d      = wdog_q;
    drain_d     = drain_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    gnt_d       = '0;
    rv_d        = '0;
    err_d       = 1'b0;
    ld_d        = 1'b0;
    st_d        = 1'b0;
    kmo_d       = 1'b0;
    case (state_q)
      IDLE: begin
        kill_pend_d = 1'b0;
        if (arb_any) begin
          owner_d = arb_idx;
          store_d = req_is_store_i[arb_idx];
          addr_d  = req_addr_i[int'(arb_idx)*ADDR_W +: ADDR_W];
          wdata_d = req_wdata_i[int'(arb_idx)*DATA_W +: DATA_W];
          gnt_d   = arb_gnt;
          ld_d    = !req_is_store_i[arb_idx];
          st_d    = req_is_store_i[arb_idx];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // A kill arriving alongside the strobe is remembered for the first wait cycle.
        last_d      = owner_q;
        wdog_d      = '0;
        kill_pend_d = req_kill_i[owner_q];
        state_d     = WAIT_RESP;
      end
      WAIT_RESP: begin
        wdog_d = wdog_inc;
        if (done) begin
          rv_d    = owner_oh;
          if (!store_q) rdata_d = ld_rdata_i;
          state_d = IDLE;
        end else if (killed) begin
          kmo_d   = 1'b1;
          drain_d = '0;
          state_d = DRAIN;
        end else if (tmo) begin
          kmo_d   = 1'b1;
          rv_d    = owner_oh;
          err_d   = 1'b1;
          drain_d = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_W'(DRAIN_CYC - 1)) state_d = IDLE;
        else                                    drain_d = drain_q + DRAIN_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      last_q      <= IDX_W'(NUM_REQ - 1);
      store_q     <= 1'b0;
      kill_pend_q <= 1'b0;
      wdog_q      <= '0;
      drain_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      gnt_q       <= '0;
      rv_q        <= '0;
      err_q       <= 1'b0;
      ld_q        <= 1'b0;
      st_q        <= 1'b0;
      kmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      store_q     <= store_d;
      kill_pend_q <= kill_pend_d;
      wdog_q      <= wdog_d;
      drain_q     <= drain_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      gnt_q       <= gnt_d;
      rv_q        <= rv_d;
      err_q       <= err_d;
      ld_q        <= ld_d;
      st_q        <= st_d;
      kmo_q       <= kmo_d;
    end
  end

  assign req_gnt_o     = gnt_q;
  assign resp_valid_o  = rv_q;
  assign resp_err_o    = err_q;
  assign resp_rdata_o  = rdata_q;
  assign is_load_o     = ld_q;
  assign is_store_o    = st_q;
  assign kill_mem_op_o = kmo_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign busy_o        = (state_q != IDLE);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_lsu_port_arbiter.sv
// Directed bench for lsu_port_arbiter: vector table for arbitration/completion, hand sequences for kill, timeout, reset.
module tb_lsu_port_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 40;
  localparam int DATA_W  = 64;
  localparam logic [ADDR_W-1:0] ADDR0 = 40'h00_0000_1000;
  localparam logic [ADDR_W-1:0] ADDR1 = 40'h80_0000_2000;
  localparam logic [DATA_W-1:0] WD0   = 64'h1111_2222_3333_4444;
  localparam logic [DATA_W-1:0] WD1   = 64'h5555_6666_7777_8888;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid_i, req_is_store_i, req_kill_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ*DATA_W-1:0] req_wdata_i;
  logic [NUM_REQ-1:0]        req_gnt_o, resp_valid_o;
  logic                      resp_err_o, is_load_o, is_store_o, kill_mem_op_o, busy_o;
  logic [DATA_W-1:0]         resp_rdata_o, mem_wdata_o, ld_rdata_i;
  logic [ADDR_W-1:0]         mem_addr_o;
  logic                      ld_resp_valid_i, st_resp_gnt_i;
  logic [1:0]                dbg_state_o;

  lsu_port_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(10), .DRAIN_CYC(2)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_is_store_i(req_is_store_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_kill_i(req_kill_i),
    .req_gnt_o(req_gnt_o), .resp_valid_o(resp_valid_o), .resp_err_o(resp_err_o),
    .resp_rdata_o(resp_rdata_o), .is_load_o(is_load_o), .is_store_o(is_store_o),
    .kill_mem_op_o(kill_mem_op_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .ld_resp_valid_i(ld_resp_valid_i), .st_resp_gnt_i(st_resp_gnt_i), .ld_rdata_i(ld_rdata_i),
    .busy_o(busy_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]        valid;
    logic [1:0]        is_store;
    int                dly;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        exp_gnt;
  } vec_t;

  vec_t              vecs[8];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] last_rd;
  int                tests = 0;
  int                fails = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid_i     = '0;
    req_is_store_i  = '0;
    req_kill_i      = '0;
    req_addr_i      = {ADDR1, ADDR0};
    req_wdata_i     = {WD1, WD0};
    ld_resp_valid_i = 1'b0;
    st_resp_gnt_i   = 1'b0;
    ld_rdata_i      = '0;
  endtask

  task automatic check_quiet(input string name);
    check({name, "_kill"}, 64'(kill_mem_op_o), 64'd0);
    check({name, "_resp"}, 64'(resp_valid_o), 64'd0);
  endtask

  initial begin
    vecs[0] = '{2'b11, 2'b00, 3, 64'hA5A5_0000_0000_0001, 2'b01};
    vecs[1] = '{2'b11, 2'b00, 3, 64'hA5A5_0000_0000_0002, 2'b10};
    vecs[2] = '{2'b11, 2'b01, 3, 64'h0,                   2'b01};
    vecs[3] = '{2'b11, 2'b00, 1, 64'hA5A5_0000_0000_0003, 2'b10};
    vecs[4] = '{2'b10, 2'b00, 1, 64'hA5A5_0000_0000_0004, 2'b10};
    vecs[5] = '{2'b01, 2'b01, 2, 64'h0,                   2'b01};
    vecs[6] = '{2'b11, 2'b10, 2, 64'h0,                   2'b10};
    vecs[7] = '{2'b11, 2'b00, 1, 64'hA5A5_0000_0000_0005, 2'b01};
    last_rd = '0;

    // Reset held with both requesters pending
    idle_inputs();
    rst = 1'b1;
    req_valid_i = 2'b11;
    repeat (3) tick();
    check("rst_ctrl", 64'({req_gnt_o, resp_valid_o, resp_err_o, is_load_o, is_store_o,
                           kill_mem_op_o, busy_o, dbg_state_o}), 64'd0);
    check("rst_addr", 64'(mem_addr_o), 64'd0);
    check("rst_wdata", mem_wdata_o, 64'd0);
    check("rst_rdata", resp_rdata_o, 64'd0);
    rst = 1'b0;

    // Table: arbitration order, strobe type, held address, completion latency
    for (int v = 0; v < 8; v++) begin
      int   own;
      logic exp_st;
      req_addr_i     = {ADDR1, ADDR0};
      req_wdata_i    = {WD1, WD0};
      req_valid_i    = vecs[v].valid;
      req_is_store_i = vecs[v].is_store;
      tick();
      own    = vecs[v].exp_gnt[1] ? 1 : 0;
      exp_st = vecs[v].is_store[own];
      check($sformatf("v%0d_gnt", v), 64'(req_gnt_o), 64'(vecs[v].exp_gnt));
      check($sformatf("v%0d_strobe", v), 64'({is_load_o, is_store_o}), 64'({!exp_st, exp_st}));
      check($sformatf("v%0d_state", v), 64'(dbg_state_o), 64'd1);
      check($sformatf("v%0d_addr", v), 64'(mem_addr_o), 64'(own == 1 ? ADDR1 : ADDR0));
      check($sformatf("v%0d_wdata", v), mem_wdata_o, own == 1 ? WD1 : WD0);
      exp_q.push_back(exp_st ? last_rd : vecs[v].rdata);
      if (!exp_st) last_rd = vecs[v].rdata;
      req_valid_i[own] = 1'b0;
      req_addr_i       = {NUM_REQ*ADDR_W{1'b1}};
      for (int k = 0; k < vecs[v].dly; k++) tick();
      check($sformatf("v%0d_hold", v), 64'({is_load_o, is_store_o, mem_addr_o}),
            64'({2'b00, own == 1 ? ADDR1 : ADDR0}));
      if (exp_st) st_resp_gnt_i = 1'b1;
      else begin
        ld_resp_valid_i = 1'b1;
        ld_rdata_i      = vecs[v].rdata;
      end
      tick();
      st_resp_gnt_i   = 1'b0;
      ld_resp_valid_i = 1'b0;
      ld_rdata_i      = '0;
      req_valid_i     = '0;
      check($sformatf("v%0d_resp", v), 64'({resp_valid_o, resp_err_o}), 64'({vecs[v].exp_gnt, 1'b0}));
      check($sformatf("v%0d_rdata", v), resp_rdata_o, exp_q.pop_front());
      check($sformatf("v%0d_idle", v), 64'(busy_o), 64'd0);
    end

    // Requester kill two cycles after grant, late load data in DRAIN ignored
    idle_inputs();
    req_valid_i = 2'b10;
    tick();
    check("kill_gnt", 64'(req_gnt_o), 64'b10);
    req_valid_i = '0;
    tick();
    tick();
    req_kill_i[1] = 1'b1;
    tick();
    req_kill_i = '0;
    check("kill_pulse", 64'({kill_mem_op_o, resp_valid_o, busy_o}), 64'b1001);
    ld_resp_valid_i = 1'b1;
    ld_rdata_i      = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    ld_resp_valid_i = 1'b0;
    check("kill_drain", 64'({kill_mem_op_o, resp_valid_o, busy_o, dbg_state_o}), 64'b000111);
    tick();
    check("kill_idle", 64'({kill_mem_op_o, resp_valid_o, busy_o}), 64'd0);
    check("kill_rdata", resp_rdata_o, last_rd);

    // Watchdog timeout, downstream silent
    idle_inputs();
    req_valid_i = 2'b01;
    tick();
    check("tmo_gnt", 64'({req_gnt_o, is_load_o}), 64'b011);
    req_valid_i = '0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("tmo_wait%0d", k), 64'({kill_mem_op_o, resp_valid_o}), 64'd0);
    end
    tick();
    check("tmo_abort", 64'({kill_mem_op_o, resp_valid_o, resp_err_o}), 64'b1011);
    tick();
    check("tmo_drain", 64'({kill_mem_op_o, resp_valid_o, busy_o}), 64'b0001);
    tick();
    check("tmo_idle", 64'(busy_o), 64'd0);
    check("tmo_rdata", resp_rdata_o, last_rd);

    // Non-owner kill ignored, then completion and owner kill together
    idle_inputs();
    req_valid_i    = 2'b10;
    req_is_store_i = 2'b10;
    tick();
    check("sim_gnt", 64'({req_gnt_o, is_store_o}), 64'b101);
    req_valid_i   = '0;
    req_kill_i[0] = 1'b1;
    tick();
    req_kill_i[0] = 1'b0;
    tick();
    check_quiet("sim_nonowner");
    check("sim_state", 64'(dbg_state_o), 64'd2);
    st_resp_gnt_i = 1'b1;
    req_kill_i[1] = 1'b1;
    tick();
    st_resp_gnt_i = 1'b0;
    req_kill_i    = '0;
    check("sim_resp", 64'({resp_valid_o, resp_err_o, kill_mem_op_o, busy_o}), 64'b10000);
    tick();
    check("sim_after", 64'({kill_mem_op_o, busy_o}), 64'd0);

    // Owner kill during ISSUE: strobe already out, abort after the first wait cycle
    idle_inputs();
    req_valid_i = 2'b01;
    tick();
    check("kiss_strobe", 64'({req_gnt_o, is_load_o}), 64'b011);
    req_valid_i   = '0;
    req_kill_i[0] = 1'b1;
    tick();
    req_kill_i = '0;
    check("kiss_wait", 64'({kill_mem_op_o, dbg_state_o}), 64'b010);
    tick();
    check("kiss_kill", 64'({kill_mem_op_o, resp_valid_o, dbg_state_o}), 64'b10011);
    tick();
    tick();
    check("kiss_idle", 64'(busy_o), 64'd0);

    // Reset in WAIT_RESP after serving requester 0: requester 0 must win again
    idle_inputs();
    req_valid_i = 2'b01;
    tick();
    check("rmid_gnt", 64'(req_gnt_o), 64'b01);
    req_valid_i = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rmid_ctrl", 64'({kill_mem_op_o, busy_o, dbg_state_o, req_gnt_o}), 64'd0);
    check("rmid_regs", 64'(mem_addr_o) | resp_rdata_o, 64'd0);
    req_valid_i = 2'b11;
    tick();
    check("rmid_regnt", 64'(req_gnt_o), 64'b01);
    check("rmid_addr", 64'(mem_addr_o), 64'(ADDR0));
    req_valid_i = '0;
    tick();
    ld_resp_valid_i = 1'b1;
    ld_rdata_i      = 64'h0123_4567_89AB_CDEF;
    tick();
    ld_resp_valid_i = 1'b0;
    check("rmid_resp", 64'({resp_valid_o, resp_err_o}), 64'b010);
    check("rmid_rdata", resp_rdata_o, 64'h0123_4567_89AB_CDEF);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu_port_arbiter.md
# lsu_port_arbiter

Shares the single load/store translation-and-dCache request port of the MEEP VAS tile between `NUM_REQ` requesters (requester 0 = scalar LSU, 1 = vector LSU by default). It arbitrates round-robin and owns the port for one transaction at a time. It drives the downstream level-sensitive `is_load`/`is_store`/`kill` handshake, returns the response to the owning requester, and aborts transactions on requester kill or watchdog timeout.

## Interface
- `NUM_REQ`, 2, number of requesters (2..4)
- `ADDR_W`, 40, virtual address width
- `DATA_W`, 64, load/store data width
- `TIMEOUT_CYC`, 255, maximum cycles in WAIT_RESP before forced abort (1..255, 8-bit counter)
- `DRAIN_CYC`, 2, cycles held in DRAIN after any kill

Ports:
- `clk  in  1  single clock, all logic posedge`
- `rst  in  1  reset, synchronous, active-high`
- `req_valid_i  in  NUM_REQ  request pending; held until its req_gnt_o`
- `req_is_store_i  in  NUM_REQ  1 = store, 0 = load`
- `req_addr_i  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]`
- `req_wdata_i  in  NUM_REQ*DATA_W  packed store data`
- `req_kill_i  in  NUM_REQ  abort own in-flight request`
- `req_gnt_o  out  NUM_REQ  one-hot, 1-cycle pulse: request accepted`
- `resp_valid_o  out  NUM_REQ  one-hot, 1-cycle pulse: transaction complete`
- `resp_err_o  out  1  qualifies resp_valid_o: 1 = timeout abort`
- `resp_rdata_o  out  DATA_W  load data, valid with resp_valid_o`
- `is_load_o / is_store_o  out  1  downstream request strobe`
- `kill_mem_op_o  out  1  downstream abort, 1-cycle pulse`
- `mem_addr_o  out  ADDR_W  held stable from ISSUE until return to IDLE`
- `mem_wdata_o  out  DATA_W  held stable, same window as mem_addr_o`
- `ld_resp_valid_i  in  1  downstream load data returned`
- `st_resp_gnt_i  in  1  downstream store accepted`
- `ld_rdata_i  in  DATA_W  load data, valid with ld_resp_valid_i`
- `busy_o  out  1  state != IDLE`

## Operation
- States are IDLE, ISSUE, WAIT_RESP and DRAIN.
- **IDLE**
  - If any `req_valid_i` is set, pick a winner by round-robin: search starts at `last_ptr+1` mod `NUM_REQ`.
  - Latch the winner's index, type, address and data, then go to ISSUE.
- **ISSUE** (exactly 1 cycle)
  - Pulse `req_gnt_o[owner]`.
  - Assert `is_load_o` or `is_store_o` per the latched type.
  - Set `last_ptr` to the owner index, clear the watchdog, go to WAIT_RESP.
- **WAIT_RESP**
  - Strobes are 0 and the watchdog increments every cycle.
  - Load completes on `ld_resp_valid_i`; store completes on `st_resp_gnt_i`. On completion, register `ld_rdata_i` (loads only), pulse `resp_valid_o[owner]` with `resp_err_o`=0, and go to IDLE.
  - On `req_kill_i[owner]`: pulse `kill_mem_op_o`, no response, go to DRAIN.
  - On watchdog = `TIMEOUT_CYC`: pulse `kill_mem_op_o`, pulse `resp_valid_o[owner]` with `resp_err_o`=1, go to DRAIN.
- **DRAIN**
  - Count `DRAIN_CYC` cycles so the downstream FSM returns to its idle state, then go to IDLE.
  - Downstream responses arriving here are ignored.
- `req_kill_i[owner]` during ISSUE: strobe still issues. The kill is registered and acted on in the first WAIT_RESP cycle.
- `req_kill_i` of a non-owner is ignored.
- **Simultaneous events in WAIT_RESP**
  - Completion and kill in the same cycle: completion wins; response delivered, no `kill_mem_op_o`.
  - Completion and timeout in the same cycle: completion wins.
- Downstream responses seen in IDLE or ISSUE are ignored.
- **Reset** (also mid-operation)
  - State → IDLE, `last_ptr` = `NUM_REQ-1` (requester 0 has first priority), watchdog = 0.
  - All outputs 0, including `mem_addr_o`, `mem_wdata_o` and `resp_rdata_o`.
  - No kill is issued; the downstream is reset on the same `rst`.

## Timing
- All outputs are registered; no combinational input→output path.
- Request seen in IDLE at cycle N → `req_gnt_o` and strobe at N+1.
- Downstream response at cycle M → `resp_valid_o` at M+1; state is IDLE at M+1, so the next grant can be at M+2.
- Minimum spacing between grants is 3 cycles for a single-cycle WAIT_RESP.
- Kill path: `kill_mem_op_o` 1 cycle, then IDLE `DRAIN_CYC` cycles after `kill_mem_op_o`.
- Worst-case latency per requester with all requesters active is `NUM_REQ-1` full transactions before its grant.

## Structure
- Shared package `lsu_arb_pkg` holds:
  - the state encoding (IDLE=2'b00, ISSUE=2'b01, WAIT_RESP=2'b10, DRAIN=2'b11);
  - `WDOG_W`=8;
  - `DRAIN_W` sized for `DRAIN_CYC`.
- Sub-module `rr_arbiter`: combinational rotating-priority pick from `req_valid_i` and `last_ptr`, giving a one-hot grant and its index.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles with `req_valid_i`=2'b11 → all outputs 0. After release, requester 0 is granted first; `mem_addr_o` = `req_addr_i[0]`.
- **Fairness:** both requesters valid continuously, downstream responds 3 cycles after each strobe → grants alternate 0,1,0,1. Each `resp_valid_o` lands 1 cycle after its response, with the correct `resp_rdata_o`.
- **Requester kill:** load from requester 1, `req_kill_i[1]` 2 cycles after grant → `kill_mem_op_o` 1 pulse, no `resp_valid_o`. `busy_o` stays high `DRAIN_CYC` cycles after the kill, then IDLE. A late `ld_resp_valid_i` during DRAIN is ignored.
- **Timeout:** `TIMEOUT_CYC`=10, downstream never responds → `kill_mem_op_o` and `resp_valid_o[owner]` with `resp_err_o`=1 together, 11 cycles after the strobe.
- **Simultaneous completion and kill:** `st_resp_gnt_i` and `req_kill_i[owner]` in the same cycle → response with `resp_err_o`=0 and no `kill_mem_op_o`. Also, a non-owner kill has no effect.
- **Reset mid-WAIT_RESP:** `rst` asserted during WAIT_RESP → IDLE next cycle, no `kill_mem_op_o`, `last_ptr` restored so requester 0 wins next.
